sr_pulse_driver: RTL and testbench

Front-end stage that drives the active-low S_n/R_n inputs of the cross-coupled SR latch. It synchronizes and debounces two raw, asynchronous request inputs (set, reset), detects their rising edges, and emits clean, fixed-width, mutually exclusive active-low pulses. The latch therefore never sees both inputs low and never sees glitches.

---
 rtl/sr_pulse_driver.sv | 118 +++++++++++
 tb/tb_sr_pulse_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: synchronize, debounce and edge-detect set/reset requests into clean, exclusive active-low latch pulses
// Ports: clk rising-edge clock; rst_n synchronous active-low reset;
//   set_in/reset_in raw async requests (active high);
//   s_n/r_n registered active-low latch drives; busy FSM not idle;
//   conflict one-cycle strobe when simultaneous requests resolve to reset;
//   set_db/reset_db debounced request levels.
module sr_pulse_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic reset_in,
  output logic s_n,
  output logic r_n,
  output logic busy,
  output logic conflict,
  output logic set_db,
  output logic reset_db
);
  localparam logic [1:0] IDLE = 2'd0, PULSE_S = 2'd1, PULSE_R = 2'd2, GAP = 2'd3;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);
  // bit 0 carries the set channel, bit 1 the reset channel
  logic [1:0] raw, sync1_q, sync2_q, db_q, db_d, dbp_q, pend_q, pend_d, rise;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic s_n_q, s_n_d, r_n_q, r_n_d, conf_q, conf_d;
  assign raw = {reset_in, set_in};
  assign rise = db_q & ~dbp_q;
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = ~db_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end
  // a rise landing in the same cycle a request is consumed stays pending
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q | rise;
    s_n_d = 1'b1;
    r_n_d = 1'b1;
    conf_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q[1]) begin
          state_d = PULSE_R;
          r_n_d = 1'b0;
          conf_d = pend_q[0];
          pend_d = rise;
        end else if (pend_q[0]) begin
          state_d = PULSE_S;
          s_n_d = 1'b0;
          pend_d[0] = rise[0];
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt_q == P_LAST) begin
          state_d = GAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          s_n_d = state_q != PULSE_S;
          r_n_d = state_q != PULSE_R;
        end
      end
      default: begin
        state_d = cnt_q == G_LAST ? IDLE : GAP;
        cnt_d = cnt_q == G_LAST ? '0 : cnt_q + CNT_W'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q <= '0;
      dbp_q <= '0;
      db_cnt_q <= '{default: '0};
      pend_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      s_n_q <= 1'b1;
      r_n_q <= 1'b1;
      conf_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q <= db_d;
      dbp_q <= db_q;
      db_cnt_q <= db_cnt_d;
      pend_q <= pend_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_n_q <= s_n_d;
      r_n_q <= r_n_d;
      conf_q <= conf_d;
    end
  end
  assign s_n = s_n_q;
  assign r_n = r_n_q;
  assign busy = state_q != IDLE;
  assign conflict = conf_q;
  assign set_db = db_q[0];
  assign reset_db = db_q[1];
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: table, directed and random checks of sr_pulse_driver against a timeline model
module tb_sr_pulse_driver;
  localparam int D = 4, P = 2, G = 1;
  logic clk = 0, rst_n = 0, set_in = 0, reset_in = 0;
  logic s_n, r_n, busy, conflict, set_db, reset_db;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  sr_pulse_driver #(.DEBOUNCE_CYCLES(D), .PULSE_WIDTH(P), .GAP_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .set_in(set_in), .reset_in(reset_in),
    .s_n(s_n), .r_n(r_n), .busy(busy), .conflict(conflict),
    .set_db(set_db), .reset_db(reset_db)
  );
  bit [1:0] m_sq1, m_sq2, m_db, m_dbp, m_pend;
  int m_run [2];
  int m_rem = 0, m_kind = 0;
  bit m_conf = 0;
  task automatic model_step();
    bit [1:0] raw, rise;
    raw = {reset_in, set_in};
    if (!rst_n) begin
      m_sq1 = 0; m_sq2 = 0; m_db = 0; m_dbp = 0; m_pend = 0;
      m_run[0] = 0; m_run[1] = 0; m_rem = 0; m_kind = 0; m_conf = 0;
      return;
    end
    rise = m_db & ~m_dbp;
    m_dbp = m_db;
    for (int i = 0; i < 2; i++) begin
      if (m_sq2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i] = ~m_db[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    m_sq2 = m_sq1;
    m_sq1 = raw;
    m_conf = 0;
    if (m_rem > 0) m_rem--;
    else if (m_pend[1]) begin
      m_kind = 2; m_rem = P + G; m_conf = m_pend[0]; m_pend = 0;
    end else if (m_pend[0]) begin
      m_kind = 1; m_rem = P + G; m_pend[0] = 0;
    end
    m_pend |= rise;
  endtask
  function automatic bit [5:0] exp_vec();
    return {!(m_kind == 1 && m_rem > G), !(m_kind == 2 && m_rem > G), m_rem > 0, m_conf, m_db[0], m_db[1]};
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    tests++;
    if ({s_n, r_n, busy, conflict, set_db, reset_db} !== exp_vec()) begin
      fails++;
      $display("FAIL model cyc=%0d got {s_n,r_n,busy,conflict,set_db,reset_db}=%b exp=%b",
               cyc, {s_n, r_n, busy, conflict, set_db, reset_db}, exp_vec());
    end
    tests++;
    if (s_n === 1'b0 && r_n === 1'b0) begin
      fails++;
      $display("FAIL both_low cyc=%0d got s_n=%b r_n=%b exp not both 0", cyc, s_n, r_n);
    end
  endtask
  task automatic check(input string name, input bit [5:0] got, input bit [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask
  typedef struct {
    bit rst;
    bit s;
    bit r;
    bit [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(bit rst, bit s, bit r, bit [5:0] exp);
    vec_t v;
    v.rst = rst; v.s = s; v.r = r; v.exp = exp;
    tbl.push_back(v);
  endfunction
  initial begin
    int rs, ss, lows, t;
    // order of exp bits: {s_n, r_n, busy, conflict, set_db, reset_db}
    for (int k = 0; k < 3; k++) add(0, 1, 0, 6'b110000);
    for (int k = 0; k < 19; k++)
      add(1, k < 12, 0, {!(k == 7 || k == 8), 1'b1, k >= 7 && k <= 9, 1'b0, k >= 5 && k < 17, 1'b0});
    for (int k = 0; k < 19; k++)
      add(1, k < 12, k < 12, {1'b1, !(k == 7 || k == 8), k >= 7 && k <= 9, k == 7, k >= 5 && k < 17, k >= 5 && k < 17});
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; set_in = tbl[i].s; reset_in = tbl[i].r;
      tick();
      check($sformatf("tbl[%0d]", i), {s_n, r_n, busy, conflict, set_db, reset_db}, tbl[i].exp);
    end
    // glitch shorter than the debounce window
    for (int k = 0; k < 13; k++) begin
      reset_in = k < 3;
      tick();
      check("glitch", {reset_db, r_n, busy}, 3'b010);
    end
    // reset request then set request arriving during the reset pulse
    rs = -1; ss = -1;
    for (int k = 0; k < 30; k++) begin
      reset_in = 1; set_in = k >= 2;
      tick();
      if (!r_n && rs < 0) rs = k;
      if (!s_n && ss < 0) ss = k;
    end
    check("b2b_r_start", 6'(rs), 6'd7);
    check("b2b_spacing", 6'(ss - rs), 6'(P + G + 1));
    set_in = 0; reset_in = 0;
    repeat (20) tick();
    // reset in the middle of a set pulse, request withdrawn
    set_in = 1;
    t = 0;
    while (s_n !== 1'b0 && t < 20) begin tick(); t++; end
    check("mid_pulse_reached", {5'b0, s_n}, 6'b0);
    set_in = 0; rst_n = 0;
    tick();
    check("mid_pulse_abort", {s_n, r_n, busy, conflict, set_db, reset_db}, 6'b110000);
    rst_n = 1;
    lows = 0;
    repeat (20) begin tick(); lows += int'(!s_n); end
    check("no_pulse_after_abort", 6'(lows), 6'd0);
    // reset held with request high, then released: request re-qualifies
    set_in = 1; rst_n = 0;
    repeat (3) begin
      tick();
      check("rst_hold", {s_n, r_n, busy, set_db}, 4'b1100);
    end
    rst_n = 1;
    t = 0;
    while (s_n !== 1'b0 && t < 20) begin tick(); t++; end
    check("requalify_latency", 6'(t), 6'd8);
    set_in = 0;
    repeat (20) tick();
    // random held levels with occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      len = int'($urandom_range(1, 12));
      set_in = 1'($urandom % 2);
      reset_in = 1'($urandom % 2);
      rst_n = ($urandom % 40) != 0;
      for (int k = 0; k < len; k++) begin
        tick();
        rst_n = 1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
